// File: rtl/vga_sram_arbiter.sv
// Arbitrates one asynchronous pixel SRAM between display fetch (fixed slot per active pixel)
// and a round-robin image writer/reader pair. Define DBL_BUF_EN for a double-buffered frame store.
module vga_sram_arbiter #(
  parameter int unsigned DW   = 8,
  parameter int unsigned AW   = 19,
  parameter int unsigned HPIX = 640
) (
  input  logic          Clk50,
  input  logic          Reset,
  input  logic          PClk,
  input  logic          Active,
  input  logic [8:0]    Row,
  input  logic [9:0]    Col,
  input  logic          Row0,
`ifdef DBL_BUF_EN
  input  logic          Swap,
`endif
  output logic [DW-1:0] PixData,
  output logic          PixValid,
  input  logic          WrReq,
  input  logic [AW-1:0] WrAddr,
  input  logic [DW-1:0] WrData,
  output logic          WrAck,
  input  logic          RdReq,
  input  logic [AW-1:0] RdAddr,
  output logic [DW-1:0] RdData,
  output logic          RdValid,
`ifdef DBL_BUF_EN
  output logic [AW:0]   SramAddr,
`else
  output logic [AW-1:0] SramAddr,
`endif
  output logic [DW-1:0] SramDout,
  input  logic [DW-1:0] SramDin,
  output logic          SramDrive,
  output logic          SramWe_n,
  output logic          SramOe_n
);

`ifdef DBL_BUF_EN
  localparam int unsigned SAW = AW + 1;
`else
  localparam int unsigned SAW = AW;
`endif

  typedef enum logic [1:0] {IDLE, DISP, CRD, CWR} state_t;

  state_t         state;
  logic           last_wr;
  logic           blank_d;
  logic [AW-1:0]  disp_addr_c;
  logic [SAW-1:0] disp_sram_c;
  logic [SAW-1:0] wr_sram_c;
  logic [SAW-1:0] rd_sram_c;
  logic           dslot_c;
  logic           rd_elig_c;
  logic           grant_wr_c;
  logic           grant_rd_c;

  // Row*HPIX + Col; 640 = 512 + 128 so the common case needs only shifts and adds
  always_comb begin
    if (HPIX == 640)
      disp_addr_c = (AW'(Row) << 9) + (AW'(Row) << 7) + AW'(Col);
    else
      disp_addr_c = AW'(Row) * AW'(HPIX) + AW'(Col);
  end

`ifdef DBL_BUF_EN
  logic disp_bank;
  logic swap_pend;

  // Bank flips only at frame start so the display never tears
  always_ff @(posedge Clk50) begin
    if (Reset) begin
      disp_bank <= 1'b0;
      swap_pend <= 1'b0;
    end else if (Row0 && (swap_pend || Swap)) begin
      disp_bank <= ~disp_bank;
      swap_pend <= 1'b0;
    end else if (Swap) begin
      swap_pend <= 1'b1;
    end
  end

  assign disp_sram_c = {disp_bank, disp_addr_c};
  assign wr_sram_c   = {~disp_bank, WrAddr};
  assign rd_sram_c   = {~disp_bank, RdAddr};
`else
  logic unused_row0;
  assign unused_row0 = Row0;
  assign disp_sram_c = disp_addr_c;
  assign wr_sram_c   = WrAddr;
  assign rd_sram_c   = RdAddr;
`endif

  // A read is not re-granted on the edge where its own access completes
  assign dslot_c    = !PClk && Active;
  assign rd_elig_c  = RdReq && (state != CRD);
  assign grant_wr_c = !dslot_c && WrReq && (!rd_elig_c || !last_wr);
  assign grant_rd_c = !dslot_c && rd_elig_c && !grant_wr_c;

  always_ff @(posedge Clk50) begin
    if (Reset) begin
      state     <= IDLE;
      last_wr   <= 1'b0;
      blank_d   <= 1'b0;
      SramAddr  <= '0;
      SramDout  <= '0;
      SramDrive <= 1'b0;
      SramWe_n  <= 1'b1;
      SramOe_n  <= 1'b1;
      WrAck     <= 1'b0;
      RdValid   <= 1'b0;
      RdData    <= '0;
      PixData   <= '0;
      PixValid  <= 1'b0;
    end else begin
      // Retire the access that this edge ends
      RdValid <= (state == CRD);
      if (state == CRD)
        RdData <= SramDin;
      if (state == DISP) begin
        PixData  <= SramDin;
        PixValid <= 1'b1;
      end else if (blank_d) begin
        PixValid <= 1'b0;
      end
      blank_d <= !PClk && !Active;
      WrAck   <= 1'b0;

      // Launch the access that this edge starts
      if (dslot_c) begin
        state     <= DISP;
        SramAddr  <= disp_sram_c;
        SramDrive <= 1'b0;
        SramWe_n  <= 1'b1;
        SramOe_n  <= 1'b0;
      end else if (grant_wr_c) begin
        state     <= CWR;
        SramAddr  <= wr_sram_c;
        SramDout  <= WrData;
        SramDrive <= 1'b1;
        SramWe_n  <= 1'b0;
        SramOe_n  <= 1'b1;
        WrAck     <= 1'b1;
        last_wr   <= 1'b1;
      end else if (grant_rd_c) begin
        state     <= CRD;
        SramAddr  <= rd_sram_c;
        SramDrive <= 1'b0;
        SramWe_n  <= 1'b1;
        SramOe_n  <= 1'b0;
        last_wr   <= 1'b0;
      end else begin
        state     <= IDLE;
        SramDrive <= 1'b0;
        SramWe_n  <= 1'b1;
        SramOe_n  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_sram_arbiter.sv
// Directed bench for vga_sram_arbiter: write/read completions go through a scoreboard
// checked by a negedge monitor; display and SRAM-pin behaviour is checked inline.
`timescale 1ns/1ps
module tb_vga_sram_arbiter;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 19;
`ifdef DBL_BUF_EN
  localparam int unsigned SAW = AW + 1;
`else
  localparam int unsigned SAW = AW;
`endif

  typedef struct packed {
    logic [SAW-1:0] addr;
    logic [DW-1:0]  data;
  } wr_exp_t;

  logic           Clk50 = 1'b0;
  logic           Reset = 1'b1;
  logic           PClk = 1'b0;
  logic           Active = 1'b0;
  logic [8:0]     Row = '0;
  logic [9:0]     Col = '0;
  logic           Row0 = 1'b0;
`ifdef DBL_BUF_EN
  logic           Swap = 1'b0;
  logic           exp_cbank = 1'b1;
`endif
  logic [DW-1:0]  PixData;
  logic           PixValid;
  logic           WrReq = 1'b0;
  logic [AW-1:0]  WrAddr = '0;
  logic [DW-1:0]  WrData = '0;
  logic           WrAck;
  logic           RdReq = 1'b0;
  logic [AW-1:0]  RdAddr = '0;
  logic [DW-1:0]  RdData;
  logic           RdValid;
  logic [SAW-1:0] SramAddr;
  logic [DW-1:0]  SramDout;
  logic [DW-1:0]  SramDin = '0;
  logic           SramDrive;
  logic           SramWe_n;
  logic           SramOe_n;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  wr_exp_t        exp_wr[$];
  logic [DW-1:0]  exp_rd[$];
  wr_exp_t        mon_we;

  vga_sram_arbiter #(.DW(DW), .AW(AW), .HPIX(640)) dut (
    .Clk50(Clk50), .Reset(Reset), .PClk(PClk), .Active(Active), .Row(Row), .Col(Col),
    .Row0(Row0),
`ifdef DBL_BUF_EN
    .Swap(Swap),
`endif
    .PixData(PixData), .PixValid(PixValid),
    .WrReq(WrReq), .WrAddr(WrAddr), .WrData(WrData), .WrAck(WrAck),
    .RdReq(RdReq), .RdAddr(RdAddr), .RdData(RdData), .RdValid(RdValid),
    .SramAddr(SramAddr), .SramDout(SramDout), .SramDin(SramDin),
    .SramDrive(SramDrive), .SramWe_n(SramWe_n), .SramOe_n(SramOe_n)
  );

  // PClk changes just after each rising edge, so the value seen at a falling edge is the next slot type
  initial forever begin
    #5 Clk50 = 1'b1;
    #1 PClk = ~PClk;
    #4 Clk50 = 1'b0;
  end

  always @(posedge Clk50) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [SAW-1:0] client_addr(input logic [AW-1:0] a);
`ifdef DBL_BUF_EN
    return {exp_cbank, a};
`else
    return a;
`endif
  endfunction

  function automatic void push_wr(input logic [SAW-1:0] a, input logic [DW-1:0] d);
    wr_exp_t e;
    e.addr = a;
    e.data = d;
    exp_wr.push_back(e);
  endfunction

  // Scoreboard monitor
  always @(negedge Clk50) begin
    if (WrAck === 1'b1) begin
      if (exp_wr.size() == 0) begin
        check("wrack_unexpected", 32'd1, 32'd0);
      end else begin
        mon_we = exp_wr.pop_front();
        check("wr_addr", 32'(SramAddr), 32'(mon_we.addr));
        check("wr_data", 32'(SramDout), 32'(mon_we.data));
        check("wr_we_n", 32'(SramWe_n), 32'd0);
        check("wr_drive", 32'(SramDrive), 32'd1);
        check("wr_oe_n", 32'(SramOe_n), 32'd1);
      end
    end
    if (RdValid === 1'b1) begin
      if (exp_rd.size() == 0)
        check("rdvalid_unexpected", 32'd1, 32'd0);
      else
        check("rd_data", 32'(RdData), 32'(exp_rd.pop_front()));
    end
  end

  task automatic wait_ack(input string name, input bit is_wr, output int at_cyc);
    bit seen;
    seen = 1'b0;
    at_cyc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk50);
      if ((is_wr && WrAck === 1'b1) || (!is_wr && RdValid === 1'b1)) begin
        seen = 1'b1;
        at_cyc = cyc;
        break;
      end
    end
    check(name, 32'(seen), 32'd1);
  endtask

  task automatic align_d();
    @(negedge Clk50);
    if (PClk) @(negedge Clk50);
  endtask

`ifdef DBL_BUF_EN
  task automatic do_write(input string name, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int c;
    push_wr(client_addr(a), d);
    WrAddr = a;
    WrData = d;
    WrReq  = 1'b1;
    wait_ack(name, 1'b1, c);
    WrReq = 1'b0;
    @(negedge Clk50);
  endtask
`endif

  initial begin
    int c_w1, c_r, c_w2, c_x;

    // Reset values
    repeat (3) @(negedge Clk50);
    check("rst_addr", 32'(SramAddr), 32'd0);
    check("rst_we_n", 32'(SramWe_n), 32'd1);
    check("rst_oe_n", 32'(SramOe_n), 32'd1);
    check("rst_drive", 32'(SramDrive), 32'd0);
    check("rst_pixvalid", 32'(PixValid), 32'd0);
    check("rst_rddata", 32'(RdData), 32'd0);

    // Write granted, then reset lands in the middle of the CWR cycle
    WrAddr = 19'd7;
    WrData = 8'h11;
    WrReq  = 1'b1;
    push_wr(client_addr(19'd7), 8'h11);
    Reset = 1'b0;
    wait_ack("rst_pre_wrack", 1'b1, c_x);
    Reset = 1'b1;
    @(negedge Clk50);
    check("rst_mid_wrack", 32'(WrAck), 32'd0);
    check("rst_mid_we_n", 32'(SramWe_n), 32'd1);
    check("rst_mid_oe_n", 32'(SramOe_n), 32'd1);
    check("rst_mid_drive", 32'(SramDrive), 32'd0);
    check("rst_mid_addr", 32'(SramAddr), 32'd0);
    check("rst_mid_dout", 32'(SramDout), 32'd0);
    @(negedge Clk50);
    check("rst_mid_wrack2", 32'(WrAck), 32'd0);
    WrReq = 1'b0;

    // Display fetch: address, latency, max address, blanking
    align_d();
    Reset   = 1'b0;
    Active  = 1'b1;
    Row     = 9'd2;
    Col     = 10'd5;
    SramDin = 8'hA5;
    @(negedge Clk50);
    check("disp_addr", 32'(SramAddr), 32'd1285);
    check("disp_oe_n", 32'(SramOe_n), 32'd0);
    check("disp_drive", 32'(SramDrive), 32'd0);
    check("disp_pix_early", 32'(PixValid), 32'd0);
    Row = 9'd479;
    Col = 10'd639;
    @(negedge Clk50);
    check("disp_pixvalid", 32'(PixValid), 32'd1);
    check("disp_pixdata", 32'(PixData), 32'hA5);
    check("idle_addr_hold", 32'(SramAddr), 32'd1285);
    check("idle_oe_n", 32'(SramOe_n), 32'd1);
    SramDin = 8'h5A;
    @(negedge Clk50);
    check("disp_addr_max", 32'(SramAddr), 32'd307199);
    @(negedge Clk50);
    check("disp_pixdata2", 32'(PixData), 32'h5A);
    Active = 1'b0;
    @(negedge Clk50);
    check("blank_pixvalid_hold", 32'(PixValid), 32'd1);
    @(negedge Clk50);
    check("blank_pixvalid", 32'(PixValid), 32'd0);
    check("blank_pixdata_hold", 32'(PixData), 32'h5A);

    // Writer alone in active video: only C-slots, single WrAck pulse
    Active = 1'b1;
    Row    = 9'd0;
    Col    = 10'd0;
    WrAddr = 19'd100;
    WrData = 8'h3C;
    WrReq  = 1'b1;
    push_wr(client_addr(19'd100), 8'h3C);
    wait_ack("act_wrack", 1'b1, c_x);
    WrReq = 1'b0;
    check("act_wr_cslot", 32'(PClk), 32'd0);
    @(negedge Clk50);
    check("act_wrack_pulse", 32'(WrAck), 32'd0);
    check("act_we_n_after", 32'(SramWe_n), 32'd1);

    // Contention from reset: writer first, then reader, then writer again
    Reset   = 1'b1;
    WrAddr  = 19'd200;
    WrData  = 8'h77;
    RdAddr  = 19'd300;
    SramDin = 8'hC3;
    WrReq   = 1'b1;
    RdReq   = 1'b1;
    push_wr(client_addr(19'd200), 8'h77);
    push_wr(client_addr(19'd200), 8'h77);
    exp_rd.push_back(8'hC3);
    repeat (2) @(negedge Clk50);
    Reset = 1'b0;
    wait_ack("rr_w1", 1'b1, c_w1);
    check("rr_w1_cslot", 32'(PClk), 32'd0);
    wait_ack("rr_r", 1'b0, c_r);
    RdReq = 1'b0;
    wait_ack("rr_w2", 1'b1, c_w2);
    WrReq = 1'b0;
    check("rr_r_gap", 32'(c_r - c_w1), 32'd3);
    check("rr_w_gap", 32'(c_w2 - c_w1), 32'd4);

    // Blanking: read then write on consecutive cycles, drive turns on with no gap
    Active = 1'b0;
    @(negedge Clk50);
    RdAddr  = 19'd55;
    RdReq   = 1'b1;
    SramDin = 8'h00;
    @(negedge Clk50);
    check("crd_addr", 32'(SramAddr), 32'(client_addr(19'd55)));
    check("crd_oe_n", 32'(SramOe_n), 32'd0);
    check("crd_drive", 32'(SramDrive), 32'd0);
    SramDin = 8'h96;
    exp_rd.push_back(8'h96);
    WrAddr = 19'd56;
    WrData = 8'hE1;
    WrReq  = 1'b1;
    push_wr(client_addr(19'd56), 8'hE1);
    wait_ack("turn_wrack", 1'b1, c_x);
    check("turn_rdvalid", 32'(RdValid), 32'd1);
    check("turn_drive_on", 32'(SramDrive), 32'd1);
    RdReq   = 1'b0;
    WrReq   = 1'b0;
    SramDin = 8'h11;
    @(negedge Clk50);
    check("turn_drive_off", 32'(SramDrive), 32'd0);
    check("turn_addr_hold", 32'(SramAddr), 32'(client_addr(19'd56)));
    check("turn_rdvalid_pulse", 32'(RdValid), 32'd0);
    check("turn_pixvalid", 32'(PixValid), 32'd0);

    // A completing read is not re-granted on its completion edge
    RdAddr = 19'd66;
    RdReq  = 1'b1;
    @(negedge Clk50);
    SramDin = 8'h4B;
    exp_rd.push_back(8'h4B);
    @(negedge Clk50);
    check("noregrant_rdvalid", 32'(RdValid), 32'd1);
    check("noregrant_oe_n", 32'(SramOe_n), 32'd1);
    RdReq = 1'b0;
    @(negedge Clk50);
    check("noregrant_rdvalid_pulse", 32'(RdValid), 32'd0);

`ifdef DBL_BUF_EN
    // Swap waits for Row0; Swap with Row0 flips immediately
    Swap = 1'b1;
    @(negedge Clk50);
    Swap = 1'b0;
    do_write("dbl_w_pend", 19'd10, 8'hA1);
    Row0 = 1'b1;
    @(negedge Clk50);
    Row0 = 1'b0;
    exp_cbank = 1'b0;
    do_write("dbl_w_flip", 19'd11, 8'hA2);
    Active = 1'b1;
    Row    = 9'd0;
    Col    = 10'd1;
    align_d();
    @(negedge Clk50);
    check("dbl_disp_bank", 32'(SramAddr), 32'((1 << AW) + 1));
    Active = 1'b0;
    Swap   = 1'b1;
    Row0   = 1'b1;
    @(negedge Clk50);
    Swap = 1'b0;
    Row0 = 1'b0;
    exp_cbank = 1'b1;
    do_write("dbl_w_same", 19'd12, 8'hA3);
`endif

    repeat (2) @(negedge Clk50);
    check("sb_wr_drained", 32'(exp_wr.size()), 32'd0);
    check("sb_rd_drained", 32'(exp_rd.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
